// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter granting one of four serial requesters a burst of bits,
// with a 4-bit pattern detector (overlapping or not) on the granted stream.
module seq_det_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [3:0] IN,
  input  logic [3:0] VLD,
  input  logic [3:0] PAT,
  input  logic       OVL,
  input  logic [3:0] BURST,
  output logic [3:0] GNT,
  output logic       OUT,
  output logic [1:0] MID,
  output logic [7:0] CNT,
  output logic       BUSY
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] gidx;
  logic [3:0] pat_l;
  logic       ovl_l;
  logic [2:0] hist;
  logic [2:0] fill;
  logic [4:0] bcnt;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;
  logic       acc;
  logic [3:0] nhist;
  logic [2:0] nfill;
  logic       match;

  // Round-robin scan starting one past the last granted requester
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = last;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Only the previous three bits are stored; the fourth is the incoming bit
  always_comb begin
    acc   = REQ[gidx] & VLD[gidx];
    nhist = {hist, IN[gidx]};
    nfill = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    match = acc && (nfill == 3'd4) && (nhist == pat_l);
  end

  assign BUSY = (state == STREAM);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      last  <= 2'd3;
      gidx  <= '0;
      pat_l <= '0;
      ovl_l <= 1'b0;
      hist  <= '0;
      fill  <= '0;
      bcnt  <= '0;
      GNT   <= '0;
      OUT   <= 1'b0;
      MID   <= '0;
      CNT   <= '0;
    end else begin
      OUT <= 1'b0;
      if (state == IDLE) begin
        if (|REQ) begin
          state <= STREAM;
          GNT   <= 4'b0001 << win;
          last  <= win;
          gidx  <= win;
          pat_l <= PAT;
          ovl_l <= OVL;
          hist  <= '0;
          fill  <= '0;
          bcnt  <= (BURST == 4'd0) ? 5'd16 : {1'b0, BURST};
        end
      end else begin
        if (!REQ[gidx]) begin
          state <= IDLE;
          GNT   <= '0;
        end else if (acc) begin
          hist <= nhist[2:0];
          fill <= (match && !ovl_l) ? 3'd0 : nfill;
          if (match) begin
            OUT <= 1'b1;
            MID <= gidx;
            if (CNT != 8'hFF)
              CNT <= CNT + 8'd1;
          end
          bcnt <= bcnt - 5'd1;
          if (bcnt == 5'd1) begin
            state <= IDLE;
            GNT   <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter: queue-based reference model compared
// every cycle, plus hand-computed expectations per scenario.
module tb_seq_det_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ, IN, VLD, PAT, BURST;
  logic       OVL;
  logic [3:0] GNT;
  logic       OUT;
  logic [1:0] MID;
  logic [7:0] CNT;
  logic       BUSY;

  seq_det_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .IN(IN), .VLD(VLD), .PAT(PAT),
    .OVL(OVL), .BURST(BURST), .GNT(GNT), .OUT(OUT), .MID(MID),
    .CNT(CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits accepted since grant start / last clear kept in a queue
  bit         m_busy = 1'b0;
  int         m_last = 3;
  int         m_g    = 0;
  int         m_left = 0;
  int         m_cnt  = 0;
  int         m_mid  = 0;
  bit         m_out  = 1'b0;
  logic [3:0] m_gnt  = '0;
  logic [3:0] m_pat  = '0;
  bit         m_ovl  = 1'b0;
  bit         q[$];

  task model_step();
    bit found;
    if (!RST) begin
      m_busy = 0; m_last = 3; m_g = 0; m_left = 0; m_cnt = 0;
      m_mid = 0; m_out = 0; m_gnt = '0;
      q.delete();
    end else begin
      m_out = 0;
      if (!m_busy) begin
        if (REQ != 4'd0) begin
          found = 0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && REQ[(m_last + k) % 4]) begin
              m_g = (m_last + k) % 4;
              found = 1;
            end
          end
          m_last = m_g;
          m_busy = 1;
          m_gnt  = 4'(1 << m_g);
          m_pat  = PAT;
          m_ovl  = OVL;
          m_left = (BURST == 4'd0) ? 16 : int'(BURST);
          q.delete();
        end
      end else if (!REQ[m_g]) begin
        m_busy = 0;
        m_gnt  = '0;
      end else if (VLD[m_g]) begin
        q.push_back(IN[m_g]);
        if (q.size() > 4) void'(q.pop_front());
        if (q.size() == 4 && {q[0], q[1], q[2], q[3]} == m_pat) begin
          m_out = 1;
          m_mid = m_g;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) q.delete();
        end
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_gnt  = '0;
        end
      end
    end
  endtask

  always @(posedge CLK or negedge RST) model_step();

  always @(negedge CLK) begin
    if (chk_en) begin
      check("gnt",  int'(GNT),  int'(m_gnt));
      check("out",  int'(OUT),  int'(m_out));
      check("mid",  int'(MID),  m_mid);
      check("cnt",  int'(CNT),  m_cnt);
      check("busy", int'(BUSY), int'(m_busy));
    end
    if (OUT === 1'b1) pulses++;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; REQ = '0; VLD = '0; IN = '0;
    tick(); tick();
    RST = 1'b1;
    tick();
  endtask

  // Grant requester g, stream n bits (MSB first), noise on the other lanes,
  // and scramble the latched-at-grant inputs right after the grant edge.
  task automatic grant_stream(input int g, input logic [3:0] p, input logic o,
                              input logic [3:0] b, input logic [15:0] bits, input int n);
    logic [3:0] onehot;
    onehot = 4'(1 << g);
    PAT = p; OVL = o; BURST = b;
    REQ = onehot;
    tick();
    PAT = ~p; OVL = ~o; BURST = b + 4'd5;
    for (int i = 0; i < n; i++) begin
      VLD = 4'hF;
      IN  = bits[n-1-i] ? onehot : ~onehot;
      tick();
    end
    VLD = '0; IN = '0;
  endtask

  int exp3 [10] = '{1, 0, 2, 0, 4, 0, 8, 0, 1, 0};
  int acc, cyc;

  initial begin
    RST = 1'b0; REQ = '0; IN = '0; VLD = '0; PAT = '0; OVL = 1'b0; BURST = '0;
    do_reset();
    chk_en = 1'b1;
    check("rst_gnt", int'(GNT), 0);
    check("rst_cnt", int'(CNT), 0);
    check("rst_busy", int'(BUSY), 0);

    // Non-overlapping 1011 over 1,0,1,1,0,1,1
    pulses = 0;
    grant_stream(0, 4'b1011, 1'b0, 4'd7, 16'b1011011, 7);
    check("s1_gnt_end", int'(GNT), 0);
    REQ = '0;
    tick(); tick();
    check("s1_pulses", pulses, 1);
    check("s1_cnt", int'(CNT), 1);
    check("s1_mid", int'(MID), 0);

    // Same stream, overlapping
    do_reset();
    pulses = 0;
    grant_stream(0, 4'b1011, 1'b1, 4'd7, 16'b1011011, 7);
    REQ = '0;
    tick(); tick();
    check("s2_pulses", pulses, 2);
    check("s2_cnt", int'(CNT), 2);

    // Round robin with BURST=1 and all requesting
    do_reset();
    BURST = 4'd1; VLD = 4'hF; IN = '0; PAT = 4'b1011; OVL = 1'b0;
    REQ = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("s3_gnt%0d", i), int'(GNT), exp3[i]);
    end
    REQ = '0; VLD = '0;
    tick(); tick();

    // BURST=0 (16 bits) with VLD gaps, overlapping 0101 on alternating bits
    pulses = 0;
    PAT = 4'b0101; OVL = 1'b1; BURST = 4'd0;
    REQ = 4'b0010;
    tick();
    check("s4_gnt", int'(GNT), 2);
    acc = 0; cyc = 0;
    while (GNT != 4'd0 && cyc < 100) begin
      if (cyc % 3 != 2) begin
        VLD = 4'b0010;
        IN  = (acc % 2 == 1) ? 4'b0010 : 4'b1101;
        acc++;
      end else begin
        VLD = 4'b1101;
        IN  = 4'hF;
      end
      cyc++;
      tick();
    end
    check("s4_gnt_dropped", int'(GNT), 0);
    check("s4_accepted", acc, 16);
    check("s4_cycles", cyc, 23);
    REQ = '0; VLD = '0;
    tick(); tick();
    check("s4_pulses", pulses, 7);
    check("s4_mid", int'(MID), 1);

    // Early release after 1,0,1 then fresh grant must start with empty history
    do_reset();
    pulses = 0;
    grant_stream(0, 4'b1011, 1'b0, 4'd7, 16'b101, 3);
    REQ = '0; VLD = 4'h1; IN = 4'h1;
    tick();
    check("s5_gnt_clear", int'(GNT), 0);
    check("s5_busy_clear", int'(BUSY), 0);
    VLD = '0;
    tick();
    check("s5_no_pulse", pulses, 0);
    grant_stream(0, 4'b1011, 1'b0, 4'd7, 16'b1011, 4);
    REQ = '0;
    tick(); tick();
    check("s5_pulses", pulses, 1);

    // Saturate CNT then reset asynchronously mid-grant
    do_reset();
    PAT = 4'b1111; OVL = 1'b1; BURST = 4'd0;
    REQ = 4'h1; VLD = 4'h1; IN = 4'h1;
    for (int i = 0; i < 400; i++) tick();
    check("s6_sat", int'(CNT), 255);
    check("s6_busy", int'(BUSY), 1);
    check("s6_out_live", int'(OUT), 1);
    #2;
    RST = 1'b0;
    #1;
    check("s6_rst_gnt", int'(GNT), 0);
    check("s6_rst_out", int'(OUT), 0);
    check("s6_rst_mid", int'(MID), 0);
    check("s6_rst_cnt", int'(CNT), 0);
    check("s6_rst_busy", int'(BUSY), 0);
    REQ = '0; VLD = '0; IN = '0;
    pulses = 0;
    tick(); tick();
    RST = 1'b1;
    tick(); tick();
    check("s6_no_pulse", pulses, 0);
    check("s6_cnt_after", int'(CNT), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
